// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift/arith ops plus a 32-cycle restoring
// divider that writes HI/LO and holds upstream through stall_o while it runs.
module ex_unit #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stall_o
);

  localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101,
                         OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111,
                         OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010,
                         OP_SRA  = 8'b0000_0011, OP_ADD  = 8'b0010_0000,
                         OP_ADDU = 8'b0010_0001, OP_SUB  = 8'b0010_0010,
                         OP_SUBU = 8'b0010_0011, OP_SLT  = 8'b0010_1010,
                         OP_SLTU = 8'b0010_1011, OP_DIV  = 8'b0001_1010,
                         OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100;

  localparam logic [DATA_W-1:0] ONE      = 1;
  localparam logic [5:0]        CNT_LAST = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DIV_ON, DIV_END} div_state_t;

  typedef struct packed {
    logic [4:0]        wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } ex_out_t;

  div_state_t        state, state_nxt;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] dvd, dvs, rem;
  logic              neg_q, neg_r;
  logic              div_stall;
  ex_out_t           out_q, out_d;

  // ---------------- single-cycle datapath
  logic [DATA_W-1:0] logic_res, shift_res, arith_res, sel_res;
  logic [DATA_W-1:0] sum, neg2, diff;
  logic              add_ov, sub_ov, ov;
  logic [4:0]        sh;

  assign sh     = reg1_i[4:0];
  assign sum    = reg1_i + reg2_i;
  assign neg2   = ~reg2_i + ONE;
  assign diff   = reg1_i + neg2;
  assign add_ov = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
  assign sub_ov = (reg1_i[DATA_W-1] == neg2[DATA_W-1]) && (diff[DATA_W-1] != reg1_i[DATA_W-1]);
  assign ov     = ((aluop_i == OP_ADD) && add_ov) || ((aluop_i == OP_SUB) && sub_ov);

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      OP_SLL:  shift_res = reg2_i << sh;
      OP_SRL:  shift_res = reg2_i >> sh;
      OP_SRA:  shift_res = $signed(reg2_i) >>> sh;
      OP_ADD, OP_ADDU: arith_res = sum;
      OP_SUB, OP_SUBU: arith_res = diff;
      OP_SLT:  arith_res = ($signed(reg1_i) < $signed(reg2_i)) ? ONE : '0;
      OP_SLTU: arith_res = (reg1_i < reg2_i) ? ONE : '0;
      default: ;
    endcase
  end

  always_comb begin
    sel_res = '0;
    case (alusel_i)
      SEL_LOGIC: sel_res = logic_res;
      SEL_SHIFT: sel_res = shift_res;
      SEL_ARITH: sel_res = arith_res;
      default:   ;
    endcase
  end

  // ---------------- divider FSM
  logic              is_div, is_sdiv;
  logic [DATA_W-1:0] abs1, abs2, q_fin, r_fin;
  logic [DATA_W:0]   trial;

  assign is_sdiv = (aluop_i == OP_DIV);
  assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
  assign abs1    = (is_sdiv && reg1_i[DATA_W-1]) ? (~reg1_i + ONE) : reg1_i;
  assign abs2    = (is_sdiv && reg2_i[DATA_W-1]) ? (~reg2_i + ONE) : reg2_i;
  // Borrow out of the trial subtraction means the partial remainder is smaller.
  assign trial   = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
  assign q_fin   = neg_q ? (~dvd + ONE) : dvd;
  assign r_fin   = neg_r ? (~rem + ONE) : rem;

  always_comb begin
    state_nxt = state;
    div_stall = 1'b0;
    case (state)
      IDLE: if (is_div) begin
        div_stall = 1'b1;
        state_nxt = (reg2_i == '0) ? DIV_END : DIV_ON;
      end
      DIV_ON: begin
        div_stall = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DIV_END;
      end
      DIV_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must drop stall immediately even if a div op sits on the inputs.
  assign stall_o = div_stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && is_div) begin
        cnt <= '0;
        rem <= '0;
        if (reg2_i == '0) begin
          dvd   <= '0;
          dvs   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          dvd   <= abs1;
          dvs   <= abs2;
          neg_q <= is_sdiv && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
          neg_r <= is_sdiv && reg1_i[DATA_W-1];
        end
      end else if (state == DIV_ON) begin
        cnt <= cnt + 6'd1;
        if (!trial[DATA_W]) begin
          rem <= trial[DATA_W-1:0];
          dvd <= {dvd[DATA_W-2:0], 1'b1};
        end else begin
          rem <= {rem[DATA_W-2:0], dvd[DATA_W-1]};
          dvd <= {dvd[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------- output register
  always_comb begin
    out_d = out_q;
    if (div_stall) begin
      out_d.wd    = '0;
      out_d.wreg  = 1'b0;
      out_d.wdata = '0;
      out_d.whilo = 1'b0;
    end else if (state == DIV_END) begin
      out_d.wd    = wd_i;
      out_d.wreg  = 1'b0;
      out_d.wdata = '0;
      out_d.whilo = 1'b1;
      out_d.hi    = r_fin;
      out_d.lo    = q_fin;
    end else begin
      out_d.wd    = wd_i;
      out_d.wreg  = wreg_i && !ov;
      out_d.wdata = sel_res;
      out_d.whilo = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign wd_o    = out_q.wd;
  assign wreg_o  = out_q.wreg;
  assign wdata_o = out_q.wdata;
  assign whilo_o = out_q.whilo;
  assign hi_o    = out_q.hi;
  assign lo_o    = out_q.lo;

endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute stage of the 5-stage pipeline; consumes decoded operation bundle (aluop, alusel, two 32-bit operands, destination, write enable) produced by the decode stage via id/ex register.
- Single-cycle logic, shift and arithmetic ops; 32-cycle iterative divider (DIV/DIVU) writing HI/LO.
- Holds upstream with stall_o while dividing; results leave through registered outputs toward the memory stage.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- DIV_CYCLES, 32, divider iterations, one quotient bit per cycle; equals DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset (`RstEnable = 1'b1`).
- aluop_i  in  8  operation code (`AluOpBus`).
- alusel_i  in  3  result class (`AluSelBus`): NOP 000, LOGIC 001, SHIFT 010, ARITH 100.
- reg1_i  in  32  operand 1 (rs value, or immediate when decode chose it).
- reg2_i  in  32  operand 2 (rt value, or immediate); also shift source.
- wd_i  in  5  destination GPR address.
- wreg_i  in  1  GPR write enable.
- wd_o  out  5  registered destination.
- wreg_o  out  1  registered GPR write enable.
- wdata_o  out  32  registered GPR write data.
- whilo_o  out  1  registered HI/LO write enable.
- hi_o  out  32  registered HI value (remainder).
- lo_o  out  32  registered LO value (quotient).
- stall_o  out  1  combinational; 1 means upstream must hold inputs stable.

Behaviour:
- Reset (async, any state): all registered outputs 0; divider returns to IDLE; stall_o = 0.
- aluop codes: NOP 00000000, AND 00100100, OR 00100101, XOR 00100110, NOR 00100111, SLL 01111100, SRL 00000010, SRA 00000011, ADD 00100000, ADDU 00100001, SUB 00100010, SUBU 00100011, SLT 00101010, SLTU 00101011, DIV 00011010, DIVU 00011011. Unlisted codes behave as NOP: result 0, wreg_o = wreg_i.
- Logic ops use reg1 op reg2.
- Shifts use reg2 shifted by reg1[4:0]; SRA replicates reg2[31].
- ADD/SUB are 32-bit modulo. On signed overflow (operand signs equal and result sign differs; for SUB, compare against the negated operand) wreg_o = 0 for that op. ADDU/SUBU never suppress.
- SLT: signed compare; SLTU: unsigned compare; result 0 or 1.
- wdata_o is selected by alusel_i; alusel NOP gives 0.
- Single-cycle ops: outputs register at the next rising edge (latency 1). whilo_o = 0.
- Divider FSM states:
  - IDLE: a DIV/DIVU arrives with reg2 != 0 -> stall_o = 1, latch absolute values (signed) or raw values (unsigned) -> DIV_ON. If reg2 == 0 -> stall_o = 1 -> DIV_END with quotient = 0, remainder = 0.
  - DIV_ON: restoring shift-subtract, one bit per cycle; 6-bit counter 0..31; stall_o = 1. After 32 iterations -> DIV_END.
  - DIV_END: apply signs for DIV (quotient negated if operand signs differ; remainder takes dividend sign). stall_o = 0. At the edge: lo_o = quotient, hi_o = remainder, whilo_o = 1, wreg_o = 0 -> IDLE unconditionally. The div op still present in this cycle must not restart.
- stall_o timing: high for 33 cycles for a nonzero divisor, 1 cycle for a zero divisor.
- Bubble while stall_o = 1: output registers load wreg_o = 0, whilo_o = 0, wdata_o = 0.
- Signed corner: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap.
- Inputs are not sampled for a new op until the cycle after DIV_END.

Test Plan:
- Reset mid-divide (counter = 10), rst pulsed asynchronously -> all outputs 0, stall_o = 0 immediately; the next OR op completes normally.
- OR 0x0000FFFF | 0x12340000, wd = 5, wreg = 1 -> next cycle wd_o = 5, wreg_o = 1, wdata_o = 0x1234FFFF, whilo_o = 0.
- ADD 0x7FFFFFFF + 1 -> wdata_o = 0x80000000, wreg_o = 0. ADDU with the same operands -> wreg_o = 1. SLT 0xFFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0.
- SRA reg2 = 0x80000010, reg1 = 4 -> 0xF8000001. SRL with the same operands -> 0x08000001.
- DIV reg1 = -7 (0xFFFFFFF9), reg2 = 2 -> stall_o high 33 cycles, then lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, whilo_o = 1 for one cycle. DIVU 100 / 7 -> lo = 14, hi = 2.
- DIVU x / 0 -> stall_o high 1 cycle; lo = hi = 0, whilo_o = 1. A back-to-back ORI after it completes at the following edge with no extra stall.
